// File: rtl/tick_seq_checker.sv
// Sequence checker for a +1 (mod 2^WIDTH) count stream: locks, counts breaks, relocks.
// Optional TICK_SEQ_CHECKER_STICKY_ERR_EN builds a sticky error flag held until reset.
module tick_seq_checker #(
    parameter int WIDTH      = 2,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] match_count,
    output logic [WIDTH-1:0] last_value,
    output logic             sticky_err
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        SYNCING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [7:0]       LOCK_RUN = 8'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic [7:0]       run_q, run_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] match_count_q, match_count_d;
    logic [WIDTH-1:0] last_value_q, last_value_d;
    logic [WIDTH-1:0] nxt;
    logic             hit;

    assign nxt = in_data + WIDTH'(1);
    assign hit = (in_data == expected_q);

    always_comb begin
        state_d       = state_q;
        expected_d    = expected_q;
        run_d         = run_q;
        locked_d      = locked_q;
        err_pulse_d   = 1'b0;
        err_count_d   = err_count_q;
        match_count_d = match_count_q;
        last_value_d  = last_value_q;
        if (in_valid) begin
            last_value_d = in_data;
            // Every accepted sample, match or not, predicts its successor.
            expected_d   = nxt;
            unique case (state_q)
                SEARCH: begin
                    state_d = SYNCING;
                    run_d   = 8'd1;
                end
                SYNCING: begin
                    if (hit) begin
                        run_d = run_q + 8'd1;
                        if (run_d == LOCK_RUN) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        run_d = 8'd1;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        if (match_count_q != CNT_MAX)
                            match_count_d = match_count_q + CNT_W'(1);
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != CNT_MAX)
                            err_count_d = err_count_q + CNT_W'(1);
                        locked_d = 1'b0;
                        state_d  = SYNCING;
                        run_d    = 8'd1;
                    end
                end
                default: begin
                    state_d  = SEARCH;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

`ifdef TICK_SEQ_CHECKER_STICKY_ERR_EN
    logic sticky_q, sticky_d;
    assign sticky_d   = sticky_q | err_pulse_d;
    assign sticky_err = sticky_q;

    always_ff @(posedge clock) begin
        if (!rst_n) sticky_q <= 1'b0;
        else        sticky_q <= sticky_d;
    end
`else
    assign sticky_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q       <= SEARCH;
            expected_q    <= '0;
            run_q         <= '0;
            locked_q      <= 1'b0;
            err_pulse_q   <= 1'b0;
            err_count_q   <= '0;
            match_count_q <= '0;
            last_value_q  <= '0;
        end else begin
            state_q       <= state_d;
            expected_q    <= expected_d;
            run_q         <= run_d;
            locked_q      <= locked_d;
            err_pulse_q   <= err_pulse_d;
            err_count_q   <= err_count_d;
            match_count_q <= match_count_d;
            last_value_q  <= last_value_d;
        end
    end

    assign locked      = locked_q;
    assign err_pulse   = err_pulse_q;
    assign err_count   = err_count_q;
    assign match_count = match_count_q;
    assign last_value  = last_value_q;

endmodule

// File: tb/tb_tick_seq_checker.sv
// Directed-vector scoreboard bench for tick_seq_checker (WIDTH=2, LOCK_COUNT=4, CNT_W=2).
// Driver queues hand-computed expectations; a monitor compares them after each edge.
module tb_tick_seq_checker;

`ifdef TICK_SEQ_CHECKER_STICKY_ERR_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_data = 2'd0;
    logic       locked, err_pulse, sticky_err;
    logic [1:0] err_count, match_count, last_value;

    typedef struct packed {
        logic       lk;
        logic       ep;
        logic [1:0] ec;
        logic [1:0] mc;
        logic [1:0] lv;
        logic       st;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_no = 0;

    tick_seq_checker #(.WIDTH(2), .LOCK_COUNT(4), .CNT_W(2)) dut (
        .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
        .match_count(match_count), .last_value(last_value), .sticky_err(sticky_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL vec %0d %s: got %0d expected %0d", vec_no, nm, got, want);
        end
    endtask

    // Monitor: compare outputs 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vec_no++;
                chk("locked", int'(locked), int'(e.lk));
                chk("err_pulse", int'(err_pulse), int'(e.ep));
                chk("err_count", int'(err_count), int'(e.ec));
                chk("match_count", int'(match_count), int'(e.mc));
                chk("last_value", int'(last_value), int'(e.lv));
                chk("sticky_err", int'(sticky_err), int'(e.st & STICKY_EN));
            end
        end
    end

    task automatic v(input bit r, input bit vl, input int d, input bit lk,
                     input bit ep, input int ec, input int mc, input int lv,
                     input bit st);
        exp_t e;
        @(negedge clock);
        rst_n    = r;
        in_valid = vl;
        in_data  = 2'(d);
        e.lk = lk;
        e.ep = ep;
        e.ec = 2'(ec);
        e.mc = 2'(mc);
        e.lv = 2'(lv);
        e.st = st;
        q.push_back(e);
    endtask

    initial begin
        // reset, including a valid sample during reset
        v(0,1,2, 0,0,0,0,0,0);
        v(0,0,0, 0,0,0,0,0,0);
        // lock and wrap
        v(1,1,0, 0,0,0,0,0,0);
        v(1,1,1, 0,0,0,0,1,0);
        v(1,1,2, 0,0,0,0,2,0);
        v(1,1,3, 1,0,0,0,3,0);
        v(1,1,0, 1,0,0,1,0,0);
        v(1,1,1, 1,0,0,2,1,0);
        v(1,1,2, 1,0,0,3,2,0);
        // break while locked, then relock
        v(0,0,0, 0,0,0,0,0,0);
        v(1,1,0, 0,0,0,0,0,0);
        v(1,1,1, 0,0,0,0,1,0);
        v(1,1,2, 0,0,0,0,2,0);
        v(1,1,3, 1,0,0,0,3,0);
        v(1,1,0, 1,0,0,1,0,0);
        v(1,1,1, 1,0,0,2,1,0);
        v(1,1,3, 0,1,1,2,3,1);
        v(1,1,0, 0,0,1,2,0,1);
        v(1,1,1, 0,0,1,2,1,1);
        v(1,1,2, 1,0,1,2,2,1);
        // back-to-back mismatches: only the first counts
        v(1,1,0, 0,1,2,2,0,1);
        v(1,1,3, 0,0,2,2,3,1);
        v(1,1,0, 0,0,2,2,0,1);
        v(1,1,1, 0,0,2,2,1,1);
        v(1,1,2, 1,0,2,2,2,1);
        v(1,0,1, 1,0,2,2,2,1);
        // idle gaps
        v(0,1,3, 0,0,0,0,0,0);
        v(1,1,0, 0,0,0,0,0,0);
        v(1,0,3, 0,0,0,0,0,0);
        v(1,0,3, 0,0,0,0,0,0);
        v(1,0,3, 0,0,0,0,0,0);
        v(1,1,1, 0,0,0,0,1,0);
        v(1,1,2, 0,0,0,0,2,0);
        v(1,1,3, 1,0,0,0,3,0);
        // five breaks with relock; err_count saturates at 3
        v(1,1,2, 0,1,1,0,2,1);
        v(1,1,3, 0,0,1,0,3,1);
        v(1,1,0, 0,0,1,0,0,1);
        v(1,1,1, 1,0,1,0,1,1);
        v(1,1,0, 0,1,2,0,0,1);
        v(1,1,1, 0,0,2,0,1,1);
        v(1,1,2, 0,0,2,0,2,1);
        v(1,1,3, 1,0,2,0,3,1);
        v(1,1,2, 0,1,3,0,2,1);
        v(1,1,3, 0,0,3,0,3,1);
        v(1,1,0, 0,0,3,0,0,1);
        v(1,1,1, 1,0,3,0,1,1);
        v(1,1,0, 0,1,3,0,0,1);
        v(1,1,1, 0,0,3,0,1,1);
        v(1,1,2, 0,0,3,0,2,1);
        v(1,1,3, 1,0,3,0,3,1);
        v(1,1,2, 0,1,3,0,2,1);
        v(1,1,3, 0,0,3,0,3,1);
        v(1,1,0, 0,0,3,0,0,1);
        v(1,1,1, 1,0,3,0,1,1);
        // match_count saturates at 3
        v(1,1,2, 1,0,3,1,2,1);
        v(1,1,3, 1,0,3,2,3,1);
        v(1,1,0, 1,0,3,3,0,1);
        v(1,1,1, 1,0,3,3,1,1);
        // reset while locked with a valid sample of 2
        v(0,1,2, 0,0,0,0,0,0);
        v(1,1,3, 0,0,0,0,3,0);
        v(1,1,0, 0,0,0,0,0,0);
        v(1,1,1, 0,0,0,0,1,0);
        v(1,1,2, 1,0,0,0,2,0);
        @(negedge clock);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
